rv32i_single_cycle_core: RTL and testbench
==========================================

// Module: rv32i_single_cycle_core
// PURPOSE
// - Single-cycle RV32I-subset CPU: PC, instr memory (imem), data memory (dcache), 32x32 register file, decoder, ALU, branch/jump unit.
// - One instruction fetched, executed and retired per clk; no pipeline, no stalls, no hazards.
// - Top of the CPU hierarchy. Programs and data are preloaded by hierarchical writes.
// - Required instance names: imem.memory[], dcache.mem[], register_file.registers[].
// PARAMETERS
// - IMEM_WORDS  256  instruction memory depth, 32-bit words
// - DMEM_WORDS  256  data memory depth, 32-bit words
// - RESET_PC    32'h0000_0000  PC value while reset is asserted
// PORTS
// - clk    input  1  system clock; all state updates on posedge
// - reset  input  1  asynchronous, active-low reset
// BEHAVIOUR
// - Reset (reset==0, async): pc<=RESET_PC; registers[0..31]<=0.
// - Reset does not clear imem or dcache contents.
// - Core has no outputs; after reset all internal state is as above.
// - Fetch: instruction = imem.memory[pc[..:2]], combinational.
// - Address wraps modulo IMEM_WORDS; pc[1:0] ignored.
// - Supported: ADDI, ADD, SUB, LW, SW, LUI, AUIPC, BEQ, JAL, JALR.
// - Any other opcode/funct executes as a NOP: no reg/mem write, pc+4.
// - Immediates are sign-extended per RV32I I/S/B/U/J formats.
//   - B and J offsets are in bytes, bit 0 forced to 0.
// - ALU is 32-bit, wraps modulo 2^32; zero = (alu_result==0).
// - Branches: ALU computes rs1-rs2; BEQ is taken when zero==1.
// - Register write: rd written at posedge when reg_write==1.
//   - Writes to x0 are discarded; x0 always reads 0.
//   - Reads are combinational; same-cycle write data appears on the next cycle.
// - Writeback source:
//   - ALU ops: alu_result
//   - LW: dcache word
//   - LUI: imm_U
//   - AUIPC: pc+imm_U
//   - JAL/JALR: pc+4
// - LW/SW address: rs1+imm, word index addr[..:2] modulo DMEM_WORDS; low 2 bits ignored.
// - SW: dcache write at posedge; LW: combinational read.
// - pc_next:
//   - JAL or taken branch: pc+imm
//   - JALR: (rs1+imm)&~1
//   - otherwise: pc+4
// - pc<=pc_next every posedge while not in reset.
// - Reset asserted mid-program: pc returns to RESET_PC immediately; next fetch restarts there.
// - Internal nets kept for debug visibility:
//   - pc, pc_next, instruction, opcode
//   - reg_write, mem_read, mem_write, jump
//   - alu_result, zero, branch_condition_match
// CONFIGURATION
// - RV_EXT_BRANCH_EN defined: also implement BNE, BLT, BGE, BLTU, BGEU.
//   - Signed/unsigned compare of rs1 vs rs2 drives branch_condition_match.
// - Undefined: only BEQ decodes; other branch funct3 values are NOPs (pc+4).
// TESTING
// - Common setup: clk period 50 ns; hold reset low 10 ns, then release.
// - Reset: pc==0 and all registers 0 during reset.
//   - First posedge after release fetches imem.memory[0].
// - ALU program, words 0..4:
//   - ADDI x4,x0,16; ADDI x1,x0,1; ADDI x2,x0,2; ADD x3,x1,x2; SUB x3,x2,x2
//   - Expect x4=0x10, x1=1, x2=2, x3=3 then 0.
// - Memory (dcache.mem[4]=0): SW x1,0(x4); LW x5,0(x4).
//   - Expect dcache.mem[4]=1 and x5=1.
// - Upper immediates: LUI x5,0x1 -> x5=0x1000; then AUIPC x5,0 at pc 0x20 -> x5=0x20.
// - Control flow:
//   - BEQ x3,x3,8 at 0x24 -> pc=0x2C; x6 and x7 stay 0.
//   - JAL x1,8 at 0x30 -> x1=0x34, pc=0x38; x8 and x9 stay 0.
//   - ADDI x10,x0,5 -> x10=5.
// - x0/JALR: ADDI x0,x0,7 leaves x0=0; JALR x0,x0,0 -> pc=0 and the program re-executes.

Source files
------------

// File: rtl/rv32i_single_cycle_core.sv
// rv32i_single_cycle_core: single-cycle RV32I-subset CPU.
// Each clk fetches, executes and retires one instruction. Supported: ADDI, ADD,
// SUB, LW, SW, LUI, AUIPC, BEQ, JAL, JALR. Anything else retires as a NOP.
// Optional feature macro: RV_EXT_BRANCH_EN adds BNE, BLT, BGE, BLTU, BGEU.
// Program and data images are preloaded through imem.memory[] and dcache.mem[].

// Instruction memory: combinational read. The write port exists for loaders;
// the core ties it off and programs arrive by hierarchical preload.
module rv32i_imem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] addr,
    output logic [31:0]   rdata
);
    logic [31:0] memory [WORDS];

    // Optional load port; contents are never cleared by reset.
    always_ff @(posedge clk) begin
        if (we) memory[waddr] <= wdata;
    end

    assign rdata = memory[addr];
endmodule

// Data memory: combinational read, write at posedge, no reset.
module rv32i_dcache #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [WORDS];

    // Store path: one word per cycle.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// 32x32 register file; x0 is never written and always reads zero.
module rv32i_register_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] wdata,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] registers [32];

    // Async clear on reset; writes to x0 are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we && (rd != 5'd0)) begin
            registers[rd] <= wdata;
        end
    end

    assign rdata1 = (rs1 == 5'd0) ? 32'h0 : registers[rs1];
    assign rdata2 = (rs2 == 5'd0) ? 32'h0 : registers[rs2];
endmodule

module rv32i_single_cycle_core #(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic reset
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_IMM, WB_PC_IMM, WB_PC4} wb_sel_t;

    logic [31:0] pc, pc_next, instruction;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        reg_write, mem_read, mem_write, jump, is_jalr, branch;
    logic        alu_src_imm, alu_sub, zero, branch_condition_match;
    wb_sel_t     wb_sel;
    logic [31:0] rs1_data, rs2_data, alu_b, alu_result, dmem_rdata, wb_data;

    rv32i_imem #(.WORDS(IMEM_WORDS)) imem (
        .clk(clk), .we(1'b0), .waddr('0), .wdata(32'h0),
        .addr(pc[IAW+1:2]), .rdata(instruction)
    );

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'h000};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    // Decoder: every control defaults to NOP, so unknown encodings retire as pc+4.
    always_comb begin
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        jump        = 1'b0;
        is_jalr     = 1'b0;
        branch      = 1'b0;
        alu_src_imm = 1'b0;
        alu_sub     = 1'b0;
        wb_sel      = WB_ALU;
        case (opcode)
            7'b0010011: if (funct3 == 3'b000) begin        // ADDI
                reg_write = 1'b1; alu_src_imm = 1'b1;
            end
            7'b0110011: if (funct3 == 3'b000) begin        // ADD / SUB
                if (funct7 == 7'b0000000) reg_write = 1'b1;
                if (funct7 == 7'b0100000) begin reg_write = 1'b1; alu_sub = 1'b1; end
            end
            7'b0000011: if (funct3 == 3'b010) begin        // LW
                reg_write = 1'b1; mem_read = 1'b1; alu_src_imm = 1'b1; wb_sel = WB_MEM;
            end
            7'b0100011: if (funct3 == 3'b010) begin        // SW
                mem_write = 1'b1; alu_src_imm = 1'b1;
            end
            7'b0110111: begin reg_write = 1'b1; wb_sel = WB_IMM;    end  // LUI
            7'b0010111: begin reg_write = 1'b1; wb_sel = WB_PC_IMM; end  // AUIPC
            7'b1100011: begin                               // branches
                alu_sub = 1'b1;
`ifdef RV_EXT_BRANCH_EN
                branch = (funct3 != 3'b010) && (funct3 != 3'b011);
`else
                branch = (funct3 == 3'b000);
`endif
            end
            7'b1101111: begin reg_write = 1'b1; jump = 1'b1; wb_sel = WB_PC4; end  // JAL
            7'b1100111: if (funct3 == 3'b000) begin        // JALR
                reg_write = 1'b1; jump = 1'b1; is_jalr = 1'b1;
                alu_src_imm = 1'b1; wb_sel = WB_PC4;
            end
            default: ;
        endcase
    end

    rv32i_register_file register_file (
        .clk(clk), .reset(reset), .we(reg_write), .rs1(rs1), .rs2(rs2), .rd(rd),
        .wdata(wb_data), .rdata1(rs1_data), .rdata2(rs2_data)
    );

    // ALU: add/sub, wrapping modulo 2^32; stores use the S-format offset.
    assign alu_b      = alu_src_imm ? (mem_write ? imm_s : imm_i) : rs2_data;
    assign alu_result = alu_sub ? (rs1_data - alu_b) : (rs1_data + alu_b);
    assign zero       = (alu_result == 32'h0);

    // Branch condition: BEQ uses the ALU zero flag; the extension adds compares.
    always_comb begin
        branch_condition_match = 1'b0;
        if (branch) begin
            case (funct3)
                3'b000:  branch_condition_match = zero;
`ifdef RV_EXT_BRANCH_EN
                3'b001:  branch_condition_match = !zero;
                3'b100:  branch_condition_match = $signed(rs1_data) <  $signed(rs2_data);
                3'b101:  branch_condition_match = $signed(rs1_data) >= $signed(rs2_data);
                3'b110:  branch_condition_match = rs1_data <  rs2_data;
                3'b111:  branch_condition_match = rs1_data >= rs2_data;
`endif
                default: branch_condition_match = 1'b0;
            endcase
        end
    end

    rv32i_dcache #(.WORDS(DMEM_WORDS)) dcache (
        .clk(clk), .we(mem_write), .addr(alu_result[DAW+1:2]),
        .wdata(rs2_data), .rdata(dmem_rdata)
    );

    // Writeback source select.
    always_comb begin
        case (wb_sel)
            WB_MEM:    wb_data = dmem_rdata;
            WB_IMM:    wb_data = imm_u;
            WB_PC_IMM: wb_data = pc + imm_u;
            WB_PC4:    wb_data = pc + 32'd4;
            default:   wb_data = alu_result;
        endcase
    end

    // Next PC: JALR target has bit 0 cleared; JAL and taken branches are pc-relative.
    always_comb begin
        pc_next = pc + 32'd4;
        if (is_jalr)                               pc_next = alu_result & ~32'h1;
        else if (jump)                             pc_next = pc + imm_j;
        else if (branch && branch_condition_match) pc_next = pc + imm_b;
    end

    // PC register: held at RESET_PC while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= RESET_PC;
        else        pc <= pc_next;
    end
endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Testbench for rv32i_single_cycle_core: directed program table, async reset
// corner cases, then random programs checked against an instruction-level model.
module tb_rv32i_single_cycle_core;
    localparam int IW = 256;
    localparam int DW = 256;

    logic clk;
    logic reset;

    rv32i_single_cycle_core dut (.clk(clk), .reset(reset));

    int tests  = 0;
    int failed = 0;

    // Reference model state (architectural view only)
    logic [31:0] m_regs [32];
    logic [31:0] m_imem [IW];
    logic [31:0] m_dmem [DW];
    logic [31:0] m_pc;
    logic [31:0] exp_q [$];

    typedef struct {
        string       name;
        logic [31:0] exp_pc;
        int          kind;      // 0: register idx, 1: data memory word idx
        int          idx;
        logic [31:0] exp_val;
    } step_t;

    step_t       steps [16];
    logic [31:0] prog  [16];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #25 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(int off, int rs2, int rs1);
        logic [11:0] o;
        o = 12'(off);
        return {o[11:5], 5'(rs2), 5'(rs1), 3'd2, o[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int off, int rs1, int rs2, int f3);
        logic [12:0] o;
        o = 13'(off);
        return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'(f3), o[4:1], o[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(int imm, int rd, int op);
        return {20'(imm), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_j(int off, int rd);
        logic [20:0] o;
        o = 21'(off);
        return {o[20], o[10:1], o[11], o[19:12], 5'(rd), 7'h6F};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_pc = 32'h0;
        exp_q.delete();
    endtask

    // Executes one instruction from the architectural rules and queues the expected pc.
    task automatic model_step();
        logic [31:0] ins, rs1v, rs2v, imm_i, imm_s, imm_b, imm_u, imm_j, nxt, val, addr;
        logic signed [31:0] ins_s;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] rd;
        logic       wr, take;
        ins   = m_imem[m_pc[9:2]];
        ins_s = ins;
        op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
        rs1v = m_regs[ins[19:15]];
        rs2v = m_regs[ins[24:20]];
        imm_i = 32'(ins_s >>> 20);
        imm_s = 32'(ins_s >>> 25) * 32 + 32'(ins[11:7]);
        imm_b = 32'(ins_s >>> 31) * 4096 + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32
              + 32'(ins[11:8]) * 2;
        imm_u = ins & 32'hFFFF_F000;
        imm_j = 32'(ins_s >>> 31) * 1048576 + 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048
              + 32'(ins[30:21]) * 2;
        nxt = m_pc + 4; wr = 1'b0; val = 32'h0; take = 1'b0;
        case (op)
            7'h13: if (f3 == 0) begin wr = 1; val = rs1v + imm_i; end
            7'h33: if (f3 == 0 && f7 == 7'h00) begin wr = 1; val = rs1v + rs2v; end
                   else if (f3 == 0 && f7 == 7'h20) begin wr = 1; val = rs1v - rs2v; end
            7'h03: if (f3 == 2) begin addr = rs1v + imm_i; wr = 1; val = m_dmem[addr[9:2]]; end
            7'h23: if (f3 == 2) begin addr = rs1v + imm_s; m_dmem[addr[9:2]] = rs2v; end
            7'h37: begin wr = 1; val = imm_u; end
            7'h17: begin wr = 1; val = m_pc + imm_u; end
            7'h63: begin
                case (f3)
                    3'd0: take = (rs1v == rs2v);
`ifdef RV_EXT_BRANCH_EN
                    3'd1: take = (rs1v != rs2v);
                    3'd4: take = ($signed(rs1v) <  $signed(rs2v));
                    3'd5: take = ($signed(rs1v) >= $signed(rs2v));
                    3'd6: take = (rs1v <  rs2v);
                    3'd7: take = (rs1v >= rs2v);
`endif
                    default: take = 1'b0;
                endcase
                if (take) nxt = m_pc + imm_b;
            end
            7'h6F: begin wr = 1; val = m_pc + 4; nxt = m_pc + imm_j; end
            7'h67: if (f3 == 0) begin wr = 1; val = m_pc + 4; nxt = (rs1v + imm_i) & ~32'h1; end
            default: ;
        endcase
        if (wr && rd != 0) m_regs[rd] = val;
        m_pc = nxt;
        exp_q.push_back(m_pc);
    endtask

    function automatic int rreg();
        return int'($urandom_range(0, 7));
    endfunction

    function automatic int roff();
        return 2 * int'($urandom_range(0, 64)) - 64;
    endfunction

    function automatic logic [31:0] rand_instr();
        case ($urandom_range(0, 12))
            0:  return enc_i(int'($urandom_range(0, 4095)), rreg(), 0, rreg(), 7'h13);
            1:  return enc_r(7'h00, rreg(), rreg(), 0, rreg());
            2:  return enc_r(7'h20, rreg(), rreg(), 0, rreg());
            3:  return enc_i(int'($urandom_range(0, 4095)), rreg(), 2, rreg(), 7'h03);
            4:  return enc_s(int'($urandom_range(0, 4095)), rreg(), rreg());
            5:  return enc_u(int'($urandom), rreg(), 7'h37);
            6:  return enc_u(int'($urandom_range(0, 15)), rreg(), 7'h17);
            7:  return enc_b(roff(), rreg(), rreg(), 0);
            8:  return enc_b(roff(), rreg(), rreg(), int'($urandom_range(1, 7)));
            9:  return enc_j(roff(), rreg());
            10: return enc_i(int'($urandom_range(0, 255)), rreg(), 0, rreg(), 7'h67);
            11: return enc_i(int'($urandom_range(0, 4095)), rreg(), int'($urandom_range(1, 7)),
                             rreg(), 7'h13);
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;

        // Directed program, word addresses 0x00..0x3C
        prog[0]  = enc_i(16, 0, 0, 4, 7'h13);       // ADDI x4,x0,16
        prog[1]  = enc_i(1, 0, 0, 1, 7'h13);        // ADDI x1,x0,1
        prog[2]  = enc_i(2, 0, 0, 2, 7'h13);        // ADDI x2,x0,2
        prog[3]  = enc_r(7'h00, 2, 1, 0, 3);        // ADD  x3,x1,x2
        prog[4]  = enc_r(7'h20, 2, 2, 0, 3);        // SUB  x3,x2,x2
        prog[5]  = enc_s(0, 1, 4);                  // SW   x1,0(x4)
        prog[6]  = enc_i(0, 4, 2, 5, 7'h03);        // LW   x5,0(x4)
        prog[7]  = enc_u(1, 5, 7'h37);              // LUI  x5,0x1
        prog[8]  = enc_u(0, 5, 7'h17);              // AUIPC x5,0 (pc 0x20)
        prog[9]  = enc_b(8, 3, 3, 0);               // BEQ  x3,x3,8 (pc 0x24)
        prog[10] = enc_i(1, 0, 0, 6, 7'h13);        // ADDI x6,x0,1 (skipped)
        prog[11] = enc_i(7, 0, 0, 0, 7'h13);        // ADDI x0,x0,7
        prog[12] = enc_j(8, 1);                     // JAL  x1,8 (pc 0x30)
        prog[13] = enc_i(1, 0, 0, 8, 7'h13);        // ADDI x8,x0,1 (skipped)
        prog[14] = enc_i(5, 0, 0, 10, 7'h13);       // ADDI x10,x0,5
        prog[15] = enc_i(0, 0, 0, 0, 7'h67);        // JALR x0,x0,0

        steps[0]  = '{"addi_x4",   32'h04, 0, 4,  32'h10};
        steps[1]  = '{"addi_x1",   32'h08, 0, 1,  32'h1};
        steps[2]  = '{"addi_x2",   32'h0C, 0, 2,  32'h2};
        steps[3]  = '{"add_x3",    32'h10, 0, 3,  32'h3};
        steps[4]  = '{"sub_x3",    32'h14, 0, 3,  32'h0};
        steps[5]  = '{"sw_mem4",   32'h18, 1, 4,  32'h1};
        steps[6]  = '{"lw_x5",     32'h1C, 0, 5,  32'h1};
        steps[7]  = '{"lui_x5",    32'h20, 0, 5,  32'h1000};
        steps[8]  = '{"auipc_x5",  32'h24, 0, 5,  32'h20};
        steps[9]  = '{"beq_x6",    32'h2C, 0, 6,  32'h0};
        steps[10] = '{"addi_x0",   32'h30, 0, 0,  32'h0};
        steps[11] = '{"jal_x1",    32'h38, 0, 1,  32'h34};
        steps[12] = '{"addi_x10",  32'h3C, 0, 10, 32'h5};
        steps[13] = '{"jalr_x8",   32'h00, 0, 8,  32'h0};
        steps[14] = '{"rerun_x4",  32'h04, 0, 4,  32'h10};
        steps[15] = '{"rerun_x1",  32'h08, 0, 1,  32'h1};

        for (int i = 0; i < IW; i++) dut.imem.memory[i] = 32'h0;
        for (int i = 0; i < 16; i++) dut.imem.memory[i] = prog[i];
        for (int i = 0; i < DW; i++) dut.dcache.mem[i] = 32'h0;

        // Reset: low 10 ns, state checked while held
        #1 reset = 1'b0;
        #5;
        check("reset_pc", dut.pc, 32'h0);
        for (int r = 0; r < 32; r++)
            check($sformatf("reset_x%0d", r), dut.register_file.registers[r], 32'h0);
        #5 reset = 1'b1;

        for (int s = 0; s < 16; s++) begin
            @(posedge clk); #1;
            check({steps[s].name, "_pc"}, dut.pc, steps[s].exp_pc);
            if (steps[s].kind == 1)
                check(steps[s].name, dut.dcache.mem[steps[s].idx], steps[s].exp_val);
            else
                check(steps[s].name, dut.register_file.registers[steps[s].idx], steps[s].exp_val);
        end
        check("x7_untouched", dut.register_file.registers[7], 32'h0);
        check("x9_untouched", dut.register_file.registers[9], 32'h0);

        // Mid-program async reset: pc and registers clear at once, memory kept
        #10 reset = 1'b0;
        #1;
        check("midreset_pc", dut.pc, 32'h0);
        check("midreset_x4", dut.register_file.registers[4], 32'h0);
        check("midreset_x10", dut.register_file.registers[10], 32'h0);
        check("midreset_mem4", dut.dcache.mem[4], 32'h1);
        #5 reset = 1'b1;
        @(posedge clk); #1;
        check("restart_pc", dut.pc, 32'h4);
        check("restart_x4", dut.register_file.registers[4], 32'h10);

        // Random programs against the instruction-level model
        for (int trial = 0; trial < 3; trial++) begin
            for (int i = 0; i < IW; i++) begin
                m_imem[i] = rand_instr();
                dut.imem.memory[i] = m_imem[i];
            end
            for (int i = 0; i < DW; i++) begin
                m_dmem[i] = $urandom;
                dut.dcache.mem[i] = m_dmem[i];
            end
            reset = 1'b0;
            #1;
            model_reset();
            check("rand_reset_pc", dut.pc, m_pc);
            #5 reset = 1'b1;
            for (int s = 0; s < 150; s++) begin
                model_step();
                @(posedge clk); #1;
                check($sformatf("rand%0d_step%0d_pc", trial, s), dut.pc, exp_q.pop_front());
                for (int r = 0; r < 32; r++)
                    check($sformatf("rand%0d_step%0d_x%0d", trial, s, r),
                          dut.register_file.registers[r], m_regs[r]);
            end
            for (int i = 0; i < DW; i++)
                check($sformatf("rand%0d_mem%0d", trial, i), dut.dcache.mem[i], m_dmem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
